// File: rtl/axi_buffer_pkg.sv
// rtl/axi_buffer_pkg.sv - shared widths and FSM state type for the AXI write buffer
package axi_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE_ADDRESS,
        DRAIN,
        RESPONSE
    } write_buffer_state_t;

endpackage

// File: rtl/axi_interface.sv
// rtl/axi_interface.sv - AXI4 bus bundle with master and slave views
interface axi_interface;

    logic [axi_buffer_pkg::ADDR_W-1:0] awaddr;
    logic [7:0]                        awlen;
    logic [2:0]                        awsize;
    logic [1:0]                        awburst;
    logic                              awvalid;
    logic                              awready;
    logic [axi_buffer_pkg::DATA_W-1:0] wdata;
    logic [axi_buffer_pkg::STRB_W-1:0] wstrb;
    logic                              wlast;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [axi_buffer_pkg::ADDR_W-1:0] araddr;
    logic [7:0]                        arlen;
    logic [2:0]                        arsize;
    logic [1:0]                        arburst;
    logic                              arvalid;
    logic                              arready;
    logic [axi_buffer_pkg::DATA_W-1:0] rdata;
    logic [1:0]                        rresp;
    logic                              rlast;
    logic                              rvalid;
    logic                              rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_wdata_fifo.sv
// rtl/axi_wdata_fifo.sv - write-beat FIFO holding {wstrb, wdata}
module axi_wdata_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 36
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = count == FULL_COUNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly PTR_W bits so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_write_buffer.sv
// rtl/axi_write_buffer.sv - store-and-forward AXI write burst buffer with read pass-through
module axi_write_buffer
    import axi_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    axi_interface.slave  axi_in,
    axi_interface.master axi_out,
    output logic         burst_overflow
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = STRB_W + DATA_W;
    localparam logic [8:0] DEPTH_BEATS = 9'(FIFO_DEPTH);

    write_buffer_state_t state;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [1:0]          aw_burst;
    logic [2:0]          aw_size;
    logic [8:0]          beat_count;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    len_minus_one;
    logic [FIFO_W-1:0]   fifo_head;
    logic                fifo_empty;
    logic                in_beat;
    logic                push;
    logic                pop;
    logic                fill_done;
    logic                last_beat;

    // wready is 1 throughout FILL, so wvalid alone marks an accepted beat.
    assign in_beat       = (state == FILL) && axi_in.wvalid;
    assign push          = in_beat && (beat_count < DEPTH_BEATS);
    assign fill_done     = in_beat && (axi_in.wlast || beat_count == {1'b0, aw_len});
    assign pop           = (state == DRAIN) && !fifo_empty && axi_out.wready;
    assign last_beat     = fifo_count == CNT_W'(1);
    assign len_minus_one = fifo_count - 1'b1;

    axi_wdata_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WIDTH     (FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data({axi_in.wstrb, axi_in.wdata}),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            aw_addr        <= '0;
            aw_len         <= '0;
            aw_burst       <= '0;
            aw_size        <= '0;
            beat_count     <= '0;
            burst_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_in.awvalid) begin
                        aw_addr    <= axi_in.awaddr;
                        aw_len     <= axi_in.awlen;
                        aw_burst   <= axi_in.awburst;
                        aw_size    <= axi_in.awsize;
                        beat_count <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (in_beat) begin
                        beat_count <= beat_count + 1'b1;
                        if (!push) begin
                            burst_overflow <= 1'b1;
                        end
                        if (fill_done) begin
                            state <= ISSUE_ADDRESS;
                        end
                    end
                end
                ISSUE_ADDRESS: begin
                    if (axi_out.awready) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last_beat) begin
                        state <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if (axi_out.bvalid && axi_in.bready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axi_in.awready  = state == IDLE;
    assign axi_in.wready   = state == FILL;

    assign axi_out.awvalid = state == ISSUE_ADDRESS;
    assign axi_out.awaddr  = aw_addr;
    assign axi_out.awlen   = 8'(len_minus_one);
    assign axi_out.awburst = aw_burst;
    assign axi_out.awsize  = aw_size;

    assign axi_out.wvalid  = (state == DRAIN) && !fifo_empty;
    assign axi_out.wdata   = fifo_head[DATA_W-1:0];
    assign axi_out.wstrb   = fifo_head[FIFO_W-1:DATA_W];
    assign axi_out.wlast   = (state == DRAIN) && last_beat;

    assign axi_in.bvalid   = (state == RESPONSE) && axi_out.bvalid;
    assign axi_in.bresp    = axi_out.bresp;
    assign axi_out.bready  = (state == RESPONSE) && axi_in.bready;

    // Read channels bypass the buffer entirely.
    assign axi_out.araddr  = axi_in.araddr;
    assign axi_out.arlen   = axi_in.arlen;
    assign axi_out.arsize  = axi_in.arsize;
    assign axi_out.arburst = axi_in.arburst;
    assign axi_out.arvalid = axi_in.arvalid;
    assign axi_in.arready  = axi_out.arready;
    assign axi_in.rdata    = axi_out.rdata;
    assign axi_in.rresp    = axi_out.rresp;
    assign axi_in.rlast    = axi_out.rlast;
    assign axi_in.rvalid   = axi_out.rvalid;
    assign axi_out.rready  = axi_in.rready;

endmodule

// File: doc/axi_write_buffer.md
AXI_WRITE_BUFFER -- requirements
Module: axi_write_buffer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the maximum number of buffered write beats; it is a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port axi_in, axi_interface.slave, bus: the upstream side, fed by an axi_interconnect master port.
REQ-005 The block SHALL have port axi_out, axi_interface.master, bus: the downstream side, feeding the memory or bridge slave.
REQ-006 The block SHALL have port burst_overflow, output, 1 bit: sticky flag, set when a burst exceeds FIFO_DEPTH beats.

Function
REQ-007 The block SHALL store and forward write bursts: it accepts a complete upstream burst, then issues it downstream.
REQ-008 The FSM SHALL have the states IDLE, FILL, ISSUE_ADDRESS, DRAIN and RESPONSE.
REQ-009 In IDLE, axi_in.awready SHALL be 1; on awvalid&&awready it SHALL latch awaddr, awlen, awburst and awsize, clear the beat count, and go to FILL next cycle.
REQ-010 In FILL, axi_in.wready SHALL be 1 and each wvalid&&wready beat SHALL push wdata and wstrb into the FIFO while the beat count is below FIFO_DEPTH.
REQ-011 FILL SHALL end on an accepted beat with wlast=1, or on beat number awlen+1, whichever comes first, and then go to ISSUE_ADDRESS.
REQ-012 Beats past FIFO_DEPTH SHALL be accepted with wready=1, then discarded, and SHALL set burst_overflow.
REQ-013 In ISSUE_ADDRESS, axi_out.awvalid SHALL be 1, with the following fields:
- awaddr, awburst, awsize as latched;
- awlen = stored beat count - 1, 8 bits.
REQ-014 ISSUE_ADDRESS SHALL move to DRAIN on axi_out.awready.
REQ-015 In DRAIN, the block SHALL drive the downstream write data as follows:
- axi_out.wvalid = FIFO not empty;
- wdata and wstrb = FIFO head;
- wlast = 1 exactly on the last stored beat.
REQ-016 In DRAIN, each wvalid&&wready SHALL pop one entry; the pop of the last entry SHALL move the FSM to RESPONSE.
REQ-017 In RESPONSE, the block SHALL pass the response through as follows:
- axi_in.bvalid = axi_out.bvalid;
- axi_out.bready = axi_in.bready.
REQ-018 On bvalid&&bready in RESPONSE, the FSM SHALL return to IDLE.
REQ-019 Outside the states named in REQ-009 to REQ-017, the following SHALL be 0: awready, wready, axi_out.awvalid, axi_out.wvalid, axi_in.bvalid and axi_out.bready.
REQ-020 The FIFO SHALL use log2(FIFO_DEPTH)-bit read and write pointers that wrap modulo FIFO_DEPTH, plus a (log2(FIFO_DEPTH)+1)-bit count; full means count==FIFO_DEPTH and empty means count==0.
REQ-021 A push and a pop SHALL never occur in the same cycle, because FILL and DRAIN are exclusive.
REQ-022 Minimum latency SHALL be as follows:
- last upstream beat at cycle N;
- axi_out.awvalid at N+1;
- first downstream wvalid at N+1 after awready, with no idle cycle.
REQ-023 The read channels (ar*, r*) SHALL pass through combinationally and unbuffered, independent of the write FSM.
REQ-024 burst_overflow SHALL clear only on reset.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE, and FIFO pointers, count, latched address/length and burst_overflow SHALL go to 0.
REQ-026 After the reset edge, every write-channel valid and ready output SHALL be 0 except axi_in.awready, which SHALL be 1.
REQ-027 Reset asserted mid-burst (FILL, DRAIN or RESPONSE) SHALL abandon the transaction and discard the buffered data, with no further downstream beats.

Structure
REQ-028 The state enum type write_buffer_state_t SHALL be defined in package axi_buffer_pkg.
REQ-029 The FIFO storage, pointers and count SHALL be one sub-module, axi_wdata_fifo, parameterised by FIFO_DEPTH and storing {wstrb, wdata}.
REQ-030 The FSM, the latched address/length registers and the read pass-through SHALL be in axi_write_buffer.

Verification
REQ-031 Upstream AW awaddr=0x100, awlen=3, four beats 0xA0..0xA3 -> downstream AW awaddr=0x100, awlen=3; beats 0xA0..0xA3 in order, wlast on 0xA3; then one B handshake passed through.
REQ-032 Upstream awlen=7 with wlast on beat 3 -> downstream awlen=3, four beats, FSM in RESPONSE after the fourth pop.
REQ-033 FIFO_DEPTH=16, awlen=19 -> twenty beats accepted, burst_overflow=1, downstream awlen=15, sixteen beats.
REQ-034 Downstream wready toggling 1,0,1,0 during DRAIN -> pops only on ready cycles, data order preserved, no duplicates.
REQ-035 Reset asserted in DRAIN after two of four beats -> next cycle IDLE, axi_out.wvalid=0, awready=1, FIFO count=0.
REQ-036 Read on axi_in.araddr=0x200, arlen=1 issued during FILL -> appears the same cycle on axi_out; rdata returned unchanged.
